pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
Parametrised chain of NUM_STAGES pipeline stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB in the default config) with a valid bit per stage and a carried payload. Each stage also has a per-stage result field that is freshly captured from that stage's own input slice. Adds what the current fixed stage registers lack: async reset, per-stage stall with upstream back-pressure, per-stage flush (bubble insertion), bubble collapse and output back-pressure. Sits between the datapath stages of the pipelined processor; stage-local logic reads the stage outputs and drives the result slices.

Parameters:
NUM_STAGES, 4, number of stage registers (>=2)
DATA_W, 64, carried payload width (PC, instruction, rd, ...), shifted unchanged stage to stage
CTRL_W, 16, control field width (RegWrite, MemWrite, Branch, ...), forced to 0 in bubbles
RES_W, 32, per-stage result field width, loaded from res_in slice of that stage

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  new entry offered to stage 0
in_data  in  DATA_W  payload for stage 0
in_ctrl  in  CTRL_W  control for stage 0
in_ready  out  1  stage 0 accepts this cycle (= ~hold[0])
res_in  in  NUM_STAGES*RES_W  slice k loaded into stage k result when stage k advances
stall  in  NUM_STAGES  per-stage hold request
flush  in  NUM_STAGES  per-stage kill of current content
out_ready  in  1  consumer of last stage accepts
stage_valid  out  NUM_STAGES  valid bit per stage
stage_data  out  NUM_STAGES*DATA_W  payload per stage, slice k = stage k
stage_ctrl  out  NUM_STAGES*CTRL_W  control per stage
stage_res  out  NUM_STAGES*RES_W  result per stage
occupancy  out  $clog2(NUM_STAGES+1)  popcount of stage_valid

Behaviour:
- Reset (rst_n=0, async): all valid, data, ctrl, res = 0 immediately. Occupancy = 0 and in_ready = 1 (unless out_ready gating; none, since pipe empty). Release is synchronous to clk via the flop; no partial state survives.
- Hold (combinational, evaluated from last stage down): hold[N] = ~out_ready; hold[k] = valid[k] & ~flush[k] & (stall[k] | hold[k+1]).
- Bubble collapse: invalid or flushed stage never holds, so upstream advances into it.
- Stall on an invalid stage has no effect.
- Incoming valid: inv[0] = in_valid; inv[k] = valid[k-1] & ~flush[k-1] & ~hold[k-1].
- Stage k update at posedge:
  - if hold[k]: all fields keep.
  - else: valid <= inv[k]; data <= upstream data (in_data for k=0); res <= res_in slice k.
  - else (cont.): ctrl <= inv[k] ? upstream ctrl : 0.
- Flush: flush[k] kills the entry in stage k this cycle. It is not passed to k+1 and does not hold stage k, which then loads from k-1 normally. Simultaneous flush[k] and stall[k]: flush wins.
- Latency: an entry accepted at edge t is in stage k after edge t+k with no holds; throughput 1/cycle.
- in_ready = ~hold[0]; an entry is accepted only when in_valid & in_ready. in_ready has a combinational path from stall/flush/out_ready; no path from in_valid.
- Outputs are direct register outputs except in_ready (comb) and occupancy (comb popcount).
- Reset mid-stream discards all entries; no hold state persists.

Decomposition:
- Package pipe_pkg: stage index constants (STG_IF_ID=0, STG_ID_EX=1, STG_EX_MEM=2, STG_MEM_WB=3) and CTRL_W bit positions (REGWRITE, REGDST, ALUSRC, MEMREAD, MEMWRITE, BRANCH, JUMP, MEMTOREG[2:0], ALUOP[1:0]) plus default widths.
- Sub-module pipe_stage_slot: one stage (valid/data/ctrl/res flops, hold/flush/load mux, ctrl zeroing), instantiated NUM_STAGES times by generate. The top computes the hold chain and flattens the buses.

Test Plan:
1. Stream 3 entries, then assert rst_n=0 between edges -> all stage_valid=0, all fields 0 before next edge, occupancy=0, in_ready=1.
2. Stream in_data=1,2,3,4 on consecutive cycles, out_ready=1, no stall -> data=1 in stage 3 after 4th edge, stage_ctrl intact; res slices captured per stage each edge.
3. Pipe full, stall[1]=1 one cycle -> stages 0,1 keep; stage 2 gets bubble (valid 0, ctrl 0); stage 3 advances; in_ready=0. Next cycle with stall released, stream resumes with no loss or duplicate.
4. stall[1]=1 with stage 0 and stage 1 both invalid -> in_ready=1, stage 0 loads in_valid entry (bubble collapse). With stage 1 invalid but stage 0 valid: stage 0 advances into stage 1.
5. Full pipe, flush[0]=flush[1]=1 with in_valid=1, data=0xAA -> after edge: stage0 valid, data 0xAA; stages 1,2 valid=0, ctrl=0; stage 3 holds old stage 2 entry. Also flush[1]+stall[1] together -> stage 1 cleared.
6. Full pipe, out_ready=0 -> all stages hold, in_ready=0, occupancy=4. Then flush[2]=1 while out_ready=0 -> stages 0,1 advance, stage 2 gets old stage 1, stage 3 holds, occupancy=3.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared stage indices, control field layout and default widths for the stage chain
package pipe_pkg;

    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_DATA_W     = 64;
    localparam int DEF_CTRL_W     = 16;
    localparam int DEF_RES_W      = 32;

    typedef enum logic [1:0] {
        STG_IF_ID  = 2'd0,
        STG_ID_EX  = 2'd1,
        STG_EX_MEM = 2'd2,
        STG_MEM_WB = 2'd3
    } stage_id_e;

    localparam int CTRL_REGWRITE     = 0;
    localparam int CTRL_REGDST       = 1;
    localparam int CTRL_ALUSRC       = 2;
    localparam int CTRL_MEMREAD      = 3;
    localparam int CTRL_MEMWRITE     = 4;
    localparam int CTRL_BRANCH       = 5;
    localparam int CTRL_JUMP         = 6;
    localparam int CTRL_MEMTOREG_LSB = 7;
    localparam int CTRL_MEMTOREG_W   = 3;
    localparam int CTRL_ALUOP_LSB    = 10;
    localparam int CTRL_ALUOP_W      = 2;

    // Same layout as the bit positions above; the top four bits are spare.
    typedef struct packed {
        logic [3:0] spare;
        logic [1:0] aluop;
        logic [2:0] memtoreg;
        logic       jump;
        logic       branch;
        logic       memwrite;
        logic       memread;
        logic       alusrc;
        logic       regdst;
        logic       regwrite;
    } ctrl_t;

endpackage

// File: rtl/pipe_stage_slot.sv
// rtl/pipe_stage_slot.sv - one pipeline stage register: valid, payload, control and result flops
module pipe_stage_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int RES_W  = DEF_RES_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [RES_W-1:0]  res_in,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [RES_W-1:0]  res
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
            res   <= '0;
        end else if (!hold) begin
            valid <= load_valid;
            data  <= up_data;
            // Bubbles carry no control so downstream never acts on stale bits.
            ctrl  <= load_valid ? up_ctrl : '0;
            res   <= res_in;
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - stage register chain with stall, flush, bubble collapse and output back-pressure
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int CTRL_W     = DEF_CTRL_W,
    parameter int RES_W      = DEF_RES_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [CTRL_W-1:0]                in_ctrl,
    output logic                             in_ready,
    input  logic [NUM_STAGES*RES_W-1:0]      res_in,
    input  logic [NUM_STAGES-1:0]            stall,
    input  logic [NUM_STAGES-1:0]            flush,
    input  logic                             out_ready,
    output logic [NUM_STAGES-1:0]            stage_valid,
    output logic [NUM_STAGES*DATA_W-1:0]     stage_data,
    output logic [NUM_STAGES*CTRL_W-1:0]     stage_ctrl,
    output logic [NUM_STAGES*RES_W-1:0]      stage_res,
    output logic [$clog2(NUM_STAGES+1)-1:0]  occupancy
);

    localparam int OCC_W = $clog2(NUM_STAGES+1);

    logic [NUM_STAGES:0]   hold;
    logic [NUM_STAGES-1:0] load_valid;

    // Hold ripples from the consumer backwards; an empty or flushed stage breaks the chain.
    always_comb begin
        hold             = '0;
        hold[NUM_STAGES] = ~out_ready;
        for (int k = NUM_STAGES-1; k >= 0; k--) begin
            hold[k] = stage_valid[k] & ~flush[k] & (stall[k] | hold[k+1]);
        end
    end

    always_comb begin
        load_valid    = '0;
        load_valid[0] = in_valid;
        for (int k = 1; k < NUM_STAGES; k++) begin
            load_valid[k] = stage_valid[k-1] & ~flush[k-1] & ~hold[k-1];
        end
    end

    assign in_ready = ~hold[0];

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            occupancy = occupancy + OCC_W'(stage_valid[k]);
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic [DATA_W-1:0] up_data;
        logic [CTRL_W-1:0] up_ctrl;

        if (k == 0) begin : g_head
            assign up_data = in_data;
            assign up_ctrl = in_ctrl;
        end else begin : g_body
            assign up_data = stage_data[(k-1)*DATA_W +: DATA_W];
            assign up_ctrl = stage_ctrl[(k-1)*CTRL_W +: CTRL_W];
        end

        pipe_stage_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W),
            .RES_W  (RES_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .hold       (hold[k]),
            .load_valid (load_valid[k]),
            .up_data    (up_data),
            .up_ctrl    (up_ctrl),
            .res_in     (res_in[k*RES_W +: RES_W]),
            .valid      (stage_valid[k]),
            .data       (stage_data[k*DATA_W +: DATA_W]),
            .ctrl       (stage_ctrl[k*CTRL_W +: CTRL_W]),
            .res        (stage_res[k*RES_W +: RES_W])
        );
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - scoreboard bench for pipe_stage_chain with directed hand-computed vectors
module tb_pipe_stage_chain;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int CW = 16;
    localparam int RW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic [CW-1:0]     in_ctrl;
    logic              in_ready;
    logic [N*RW-1:0]   res_in;
    logic [N-1:0]      stall;
    logic [N-1:0]      flush;
    logic              out_ready;
    logic [N-1:0]      stage_valid;
    logic [N*DW-1:0]   stage_data;
    logic [N*CW-1:0]   stage_ctrl;
    logic [N*RW-1:0]   stage_res;
    logic [2:0]        occupancy;

    pipe_stage_chain #(.NUM_STAGES(N), .DATA_W(DW), .CTRL_W(CW), .RES_W(RW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .in_ready    (in_ready),
        .res_in      (res_in),
        .stall       (stall),
        .flush       (flush),
        .out_ready   (out_ready),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .stage_ctrl  (stage_ctrl),
        .stage_res   (stage_res),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [3:0]  v;
        logic [31:0] d;
        bit          rdy;
        bit          zero;
        bit          cres;
        logic [7:0]  rtag;
    } snap_t;

    snap_t      snap_q[$];
    logic [7:0] exit_q[$];
    snap_t      sn;
    logic [7:0] ex;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exit_n = 0;
    logic [7:0] prev_tag = 8'h00;
    bit         end_chk = 1'b0;
    bit         end_done = 1'b0;

    function automatic logic [63:0] fd(input logic [7:0] b);
        return 64'hDEAD_0000_0000_0000 | {56'h0, b};
    endfunction

    function automatic logic [15:0] mk_ctrl(input logic [7:0] b);
        return {8'hC5, b};
    endfunction

    task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step%0d actual=%h required=%h", nm, id, act, exp);
        end
    endtask

    // Monitor: pops expected snapshots and expected exits, compares against what the DUT presents.
    always @(negedge clk) begin
        if (snap_q.size() != 0) begin
            sn = snap_q.pop_front();
            chk("stage_valid", sn.id, 64'(stage_valid), 64'(sn.v));
            chk("occupancy", sn.id, 64'(occupancy), 64'($countones(sn.v)));
            chk("in_ready", sn.id, 64'(in_ready), 64'(sn.rdy));
            for (int k = 0; k < N; k++) begin
                if (sn.v[k]) begin
                    chk($sformatf("data%0d", k), sn.id, stage_data[k*DW +: DW], fd(sn.d[k*8 +: 8]));
                    chk($sformatf("ctrl%0d", k), sn.id, 64'(stage_ctrl[k*CW +: CW]), 64'(mk_ctrl(sn.d[k*8 +: 8])));
                end else begin
                    chk($sformatf("bubble_ctrl%0d", k), sn.id, 64'(stage_ctrl[k*CW +: CW]), 64'h0);
                end
                if (sn.cres)
                    chk($sformatf("res%0d", k), sn.id, 64'(stage_res[k*RW +: RW]), 64'(32'(k*256) + 32'(sn.rtag)));
            end
            if (sn.zero)
                chk("reset_fields_zero", sn.id, 64'(|{stage_data, stage_ctrl, stage_res}), 64'h0);
        end
        if (rst_n && stage_valid[N-1] && out_ready) begin
            if (exit_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL exit_unexpected actual=%h required=none", stage_data[(N-1)*DW +: DW]);
            end else begin
                ex = exit_q.pop_front();
                chk("exit_data", exit_n, stage_data[(N-1)*DW +: DW], fd(ex));
                chk("exit_ctrl", exit_n, 64'(stage_ctrl[(N-1)*CW +: CW]), 64'(mk_ctrl(ex)));
            end
            exit_n++;
        end
        if (end_chk && !end_done) begin
            end_done <= 1'b1;
            chk("exit_queue_left", 0, 64'(exit_q.size()), 64'h0);
            chk("snap_queue_left", 0, 64'(snap_q.size()), 64'h0);
        end
    end

    task automatic drive(input bit iv, input logic [7:0] d, input logic [3:0] st, input logic [3:0] fl,
                         input bit ordy, input logic [7:0] tag);
        in_valid  = iv;
        in_data   = fd(d);
        in_ctrl   = mk_ctrl(d);
        stall     = st;
        flush     = fl;
        out_ready = ordy;
        for (int k = 0; k < N; k++) res_in[k*RW +: RW] = 32'(k*256) + 32'(tag);
    endtask

    // Applies inputs for the coming edge and records the state expected before that edge.
    task automatic step(input int id, input bit iv, input logic [7:0] d, input logic [3:0] st,
                        input logic [3:0] fl, input bit ordy, input logic [3:0] ev,
                        input logic [31:0] ed, input bit erdy, input bit cres);
        snap_t s;
        drive(iv, d, st, fl, ordy, 8'(id));
        s.id = id; s.v = ev; s.d = ed; s.rdy = erdy; s.zero = 1'b0; s.cres = cres; s.rtag = prev_tag;
        snap_q.push_back(s);
        prev_tag = 8'(id);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse(input int id);
        snap_t s;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 8'(id));
        s.id = id; s.v = 4'h0; s.d = 32'h0; s.rdy = 1'b1; s.zero = 1'b1; s.cres = 1'b0; s.rtag = 8'h0;
        snap_q.push_back(s);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        res_in = '0;
        drive(1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 8'h00);
        reset_pulse(0);
        @(posedge clk);
        #1;

        // Partial fill, then asynchronous reset between edges.
        step(1, 1, 8'h01, 4'h0, 4'h0, 1, 4'b0000, 32'h00000000, 1, 0);
        step(2, 1, 8'h02, 4'h0, 4'h0, 1, 4'b0001, 32'h00000001, 1, 0);
        step(3, 1, 8'h03, 4'h0, 4'h0, 1, 4'b0011, 32'h00000102, 1, 0);
        reset_pulse(4);

        // Straight stream, result slices checked each edge.
        exit_q.push_back(8'h01);
        step(10, 1, 8'h01, 4'h0, 4'h0, 1, 4'b0000, 32'h00000000, 1, 0);
        step(11, 1, 8'h02, 4'h0, 4'h0, 1, 4'b0001, 32'h00000001, 1, 1);
        step(12, 1, 8'h03, 4'h0, 4'h0, 1, 4'b0011, 32'h00000102, 1, 1);
        step(13, 1, 8'h04, 4'h0, 4'h0, 1, 4'b0111, 32'h00010203, 1, 1);
        step(14, 1, 8'h05, 4'h0, 4'h0, 1, 4'b1111, 32'h01020304, 1, 1);

        // Stall stage 1 on a full pipe, then release and drain.
        exit_q.push_back(8'h02); exit_q.push_back(8'h03); exit_q.push_back(8'h04);
        exit_q.push_back(8'h05); exit_q.push_back(8'h06); exit_q.push_back(8'h07);
        step(15, 1, 8'h06, 4'b0010, 4'h0, 1, 4'b1111, 32'h02030405, 0, 1);
        step(16, 1, 8'h06, 4'h0, 4'h0, 1, 4'b1011, 32'h03000405, 1, 0);
        step(17, 1, 8'h07, 4'h0, 4'h0, 1, 4'b0111, 32'h00040506, 1, 0);
        step(18, 0, 8'h00, 4'h0, 4'h0, 1, 4'b1111, 32'h04050607, 1, 0);
        step(19, 0, 8'h00, 4'h0, 4'h0, 1, 4'b1110, 32'h05060700, 1, 0);
        step(20, 0, 8'h00, 4'h0, 4'h0, 1, 4'b1100, 32'h06070000, 1, 0);
        step(21, 0, 8'h00, 4'h0, 4'h0, 1, 4'b1000, 32'h07000000, 1, 0);

        // Stall on empty stages collapses bubbles.
        exit_q.push_back(8'h08);
        step(22, 1, 8'h08, 4'b0010, 4'h0, 1, 4'b0000, 32'h00000000, 1, 0);
        step(23, 0, 8'h00, 4'b0010, 4'h0, 1, 4'b0001, 32'h00000008, 1, 0);
        step(24, 0, 8'h00, 4'b0010, 4'h0, 1, 4'b0010, 32'h00000800, 1, 0);
        step(25, 1, 8'h09, 4'h0, 4'h0, 1, 4'b0010, 32'h00000800, 1, 0);
        step(26, 1, 8'h0A, 4'h0, 4'h0, 1, 4'b0101, 32'h00080009, 1, 0);
        step(27, 1, 8'h0B, 4'h0, 4'h0, 1, 4'b1011, 32'h0800090A, 1, 0);
        step(28, 1, 8'h0C, 4'h0, 4'h0, 1, 4'b0111, 32'h00090A0B, 1, 0);

        // Flush stages 0 and 1 while a new entry arrives; then flush+stall together.
        exit_q.push_back(8'h09); exit_q.push_back(8'h0A);
        step(29, 1, 8'hAA, 4'h0, 4'b0011, 1, 4'b1111, 32'h090A0B0C, 1, 0);
        step(30, 1, 8'h0D, 4'h0, 4'h0, 1, 4'b1001, 32'h0A0000AA, 1, 0);
        step(31, 0, 8'h00, 4'b0010, 4'b0010, 1, 4'b0011, 32'h0000AA0D, 1, 0);

        // Output back-pressure, then flush of stage 2 under back-pressure.
        exit_q.push_back(8'h0D); exit_q.push_back(8'h0E);
        exit_q.push_back(8'h10); exit_q.push_back(8'h11);
        step(32, 1, 8'h0E, 4'h0, 4'h0, 1, 4'b0010, 32'h00000D00, 1, 0);
        step(33, 1, 8'h0F, 4'h0, 4'h0, 1, 4'b0101, 32'h000D000E, 1, 0);
        step(34, 1, 8'h10, 4'h0, 4'h0, 1, 4'b1011, 32'h0D000E0F, 1, 0);
        step(35, 1, 8'h11, 4'h0, 4'h0, 0, 4'b0111, 32'h000E0F10, 1, 0);
        step(36, 1, 8'h12, 4'h0, 4'h0, 0, 4'b1111, 32'h0E0F1011, 0, 0);
        step(37, 0, 8'h00, 4'h0, 4'b0100, 0, 4'b1111, 32'h0E0F1011, 1, 0);
        step(38, 0, 8'h00, 4'h0, 4'h0, 1, 4'b1110, 32'h0E101100, 1, 0);
        step(39, 0, 8'h00, 4'h0, 4'h0, 1, 4'b1100, 32'h10110000, 1, 0);
        step(40, 0, 8'h00, 4'h0, 4'h0, 1, 4'b1000, 32'h11000000, 1, 0);
        step(41, 0, 8'h00, 4'h0, 4'h0, 1, 4'b0000, 32'h00000000, 1, 0);

        end_chk = 1'b1;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
